// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle variable-distance shift controller driving a single-bit shifter
module shift_sequencer #(
    parameter int k = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [k-1:0] din,
    input  logic [1:0]   op,
    input  logic [3:0]   amount,
    output logic [k-1:0] sh_in,
    output logic [1:0]   sh_sel,
    input  logic [k-1:0] sh_out,
    output logic         busy,
    output logic         done,
    output logic [k-1:0] dout
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t       state_q, state_d;
    logic [k-1:0] acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [1:0]   op_q, op_d;
    // state and datapath registers, cleared immediately on reset so a running job is aborted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end
    // job acceptance in IDLE/DONE, one shifter step per SHIFT cycle until the count is spent
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (state_q == SHIFT) begin
            acc_d   = sh_out;
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? DONE : SHIFT;
        end else if (start) begin
            acc_d   = din;
            cnt_d   = amount;
            op_d    = op;
            state_d = (amount == 4'd0 || op == 2'b00) ? DONE : SHIFT;
        end else begin
            state_d = IDLE;
        end
    end
    assign sh_in  = acc_q;
    assign sh_sel = (state_q == SHIFT) ? op_q : 2'b00;
    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign dout   = acc_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against an arithmetic model
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = '0;
    logic [1:0]  op = 2'b00;
    logic [3:0]  amount = '0;
    logic [15:0] sh_in, sh_out, dout;
    logic [1:0]  sh_sel;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;

    shift_sequencer #(.k(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .din(din), .op(op), .amount(amount),
        .sh_in(sh_in), .sh_sel(sh_sel), .sh_out(sh_out), .busy(busy), .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    // single-bit shifter the sequencer is expected to drive
    assign sh_out = (sh_sel == 2'b01) ? {sh_in[14:0], 1'b0} :
                    (sh_sel == 2'b10) ? {1'b0, sh_in[15:1]} :
                    (sh_sel == 2'b11) ? {sh_in[15], sh_in[15:1]} : sh_in;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a);
        int v;
        v = (o == 2'b11 && d[15]) ? int'(d) - 65536 : int'(d);
        case (o)
            2'b01:   return 16'(d << a);
            2'b10:   return d >> a;
            2'b11:   return 16'(v >>> a);
            default: return d;
        endcase
    endfunction

    task automatic start_job(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a);
        @(negedge clk);
        start = 1'b1; din = d; op = o; amount = a;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_job(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a, input bit inject);
        int n;
        n = (o == 2'b00 || a == 4'd0) ? 0 : int'(a);
        for (int i = 0; i < n; i++) begin
            check("busy_in_shift", {15'd0, busy}, 16'd1);
            check("done_in_shift", {15'd0, done}, 16'd0);
            check("sel_in_shift", {14'd0, sh_sel}, {14'd0, o});
            if (inject && i == 0) begin
                @(negedge clk);
                start = 1'b1; din = 16'hFFFF; op = 2'b00; amount = 4'd0;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        check("done_pulse", {15'd0, done}, 16'd1);
        check("busy_at_done", {15'd0, busy}, 16'd0);
        check("sel_at_done", {14'd0, sh_sel}, 16'd0);
        check("dout", dout, model(d, o, a));
    endtask

    task automatic idle_cycle(input logic [15:0] held);
        @(posedge clk);
        #1;
        check("done_single", {15'd0, done}, 16'd0);
        check("busy_idle", {15'd0, busy}, 16'd0);
        check("sel_idle", {14'd0, sh_sel}, 16'd0);
        check("dout_hold", dout, held);
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  o;
        logic [3:0]  a;
        #2;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_dout", dout, 16'd0);
        check("rst_shin", sh_in, 16'd0);
        check("rst_sel", {14'd0, sh_sel}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        start_job(16'h8001, 2'b01, 4'd3); wait_job(16'h8001, 2'b01, 4'd3, 1'b0);
        check("tp_left3", dout, 16'h0008);
        idle_cycle(16'h0008);
        start_job(16'h8000, 2'b11, 4'd4); wait_job(16'h8000, 2'b11, 4'd4, 1'b0);
        check("tp_asr4", dout, 16'hF800);
        idle_cycle(16'hF800);
        start_job(16'h8000, 2'b10, 4'd4); wait_job(16'h8000, 2'b10, 4'd4, 1'b0);
        check("tp_lsr4", dout, 16'h0800);
        idle_cycle(16'h0800);
        start_job(16'hFFFF, 2'b10, 4'd15); wait_job(16'hFFFF, 2'b10, 4'd15, 1'b0);
        check("tp_lsr15", dout, 16'h0001);
        idle_cycle(16'h0001);
        start_job(16'h1234, 2'b01, 4'd0); wait_job(16'h1234, 2'b01, 4'd0, 1'b0);
        check("tp_amt0", dout, 16'h1234);
        idle_cycle(16'h1234);
        start_job(16'hBEEF, 2'b00, 4'd9); wait_job(16'hBEEF, 2'b00, 4'd9, 1'b0);
        idle_cycle(16'hBEEF);
        start_job(16'h0001, 2'b01, 4'd2); wait_job(16'h0001, 2'b01, 4'd2, 1'b1);
        check("tp_jobA", dout, 16'h0004);
        start_job(16'h0010, 2'b10, 4'd1); wait_job(16'h0010, 2'b10, 4'd1, 1'b0);
        check("tp_jobB", dout, 16'h0008);
        idle_cycle(16'h0008);

        start_job(16'h00F0, 2'b01, 4'd8);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_dout", dout, 16'd0);
        check("abort_sel", {14'd0, sh_sel}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start_job(16'h00F0, 2'b01, 4'd8); wait_job(16'h00F0, 2'b01, 4'd8, 1'b0);
        idle_cycle(16'hF000);

        d = 16'h0; o = 2'b00; a = 4'd0;
        for (int j = 0; j < 40; j++) begin
            d = 16'($urandom);
            o = 2'($urandom);
            a = 4'($urandom);
            start_job(d, o, a);
            wait_job(d, o, a, (o != 2'b00 && a != 4'd0 && $urandom_range(0, 2) == 0));
            if ($urandom_range(0, 1) == 0) idle_cycle(model(d, o, a));
        end
        idle_cycle(model(d, o, a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
